// File: rtl/fb_rect_fill_pkg.sv
// Shared frame-buffer geometry defaults and fill-engine state encoding.
// The VGA scan-out side is built from the same constants.
package fb_rect_fill_pkg;

  localparam int DEF_FB_WIDTH         = 400;
  localparam int DEF_FB_HEIGHT        = 300;
  localparam int DEF_X_BITS           = 9;
  localparam int DEF_Y_BITS           = 9;
  localparam int DEF_BUFFER_ADDR_BITS = 17;
  localparam int DEF_CHANNEL_BITS     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fb_rect_fill_write_lane.sv
// Byte-lane steering for the 32-bit frame-buffer write port: one pixel byte per write,
// lane selected by the low two address bits, colour replicated on every lane.
module fb_rect_fill_write_lane
  import fb_rect_fill_pkg::*;
#(
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS
) (
  input  logic                      en,
  input  logic [1:0]                lane,
  input  logic [3*CHANNEL_BITS-1:0] color,
  output logic [3:0]                we,
  output logic [31:0]               din
);

  localparam int PAD_BITS = 8 - 3 * CHANNEL_BITS;

  logic [7:0] pixel_byte;
  assign pixel_byte = {{PAD_BITS{1'b0}}, color};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign we[gi]          = en && (lane == 2'(gi));
    assign din[8*gi +: 8]  = en ? pixel_byte : 8'd0;
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes one colour byte per clock over a clipped rectangle,
// row-major, into the frame-buffer BRAM write port.
module fb_rect_fill
  import fb_rect_fill_pkg::*;
#(
  parameter int FB_WIDTH         = DEF_FB_WIDTH,
  parameter int FB_HEIGHT        = DEF_FB_HEIGHT,
  parameter int X_BITS           = DEF_X_BITS,
  parameter int Y_BITS           = DEF_Y_BITS,
  parameter int BUFFER_ADDR_BITS = DEF_BUFFER_ADDR_BITS,
  parameter int CHANNEL_BITS     = DEF_CHANNEL_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [X_BITS-1:0]         cmd_x0,
  input  logic [Y_BITS-1:0]         cmd_y0,
  input  logic [X_BITS-1:0]         cmd_x1,
  input  logic [Y_BITS-1:0]         cmd_y1,
  input  logic [3*CHANNEL_BITS-1:0] cmd_color,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               buffer_addr,
  output logic [31:0]               buffer_din,
  output logic                      buffer_en,
  output logic                      buffer_rst,
  output logic [3:0]                buffer_we
);

  localparam int COLOR_BITS = 3 * CHANNEL_BITS;
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(FB_HEIGHT - 1);
  localparam logic [BUFFER_ADDR_BITS-1:0] ROW_STEP = BUFFER_ADDR_BITS'(FB_WIDTH);

  fill_state_t                 state_reg;
  logic [X_BITS-1:0]           x_reg, x0_reg, x1_reg;
  logic [Y_BITS-1:0]           y_reg, y1_reg;
  logic [BUFFER_ADDR_BITS-1:0] row_base_reg, addr_reg;
  logic [COLOR_BITS-1:0]       color_reg;
  logic                        cmd_ready_reg, busy_reg, done_reg, en_reg;
  logic [3:0]                  we_reg;
  logic [31:0]                 din_reg;

  logic [X_BITS-1:0]           x1_clip;
  logic [Y_BITS-1:0]           y1_clip;
  logic                        cmd_empty, cmd_accept;
  logic [BUFFER_ADDR_BITS-1:0] start_row_base;
  logic                        row_end, last_pixel;

  assign x1_clip    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign y1_clip    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  assign cmd_empty  = (cmd_x0 > x1_clip) || (cmd_y0 > y1_clip) ||
                      (cmd_x0 > X_MAX)   || (cmd_y0 > Y_MAX);
  assign cmd_accept = cmd_valid && (state_reg == ST_IDLE);

  // Only multiply in the design; evaluated once per command, never inside the pixel loop.
  assign start_row_base = BUFFER_ADDR_BITS'(cmd_y0) * ROW_STEP;

  assign row_end    = (x_reg == x1_reg);
  assign last_pixel = row_end && (y_reg == y1_reg);

  // Next write cycle, computed a cycle ahead so every bus output leaves a flop.
  logic                        wr_next_en;
  logic [BUFFER_ADDR_BITS-1:0] wr_next_addr;
  logic [COLOR_BITS-1:0]       wr_next_color;
  logic [3:0]                  lane_we;
  logic [31:0]                 lane_din;

  always_comb begin
    wr_next_en    = 1'b0;
    wr_next_addr  = addr_reg;
    wr_next_color = color_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_accept && !cmd_empty) begin
          wr_next_en    = 1'b1;
          wr_next_addr  = start_row_base + BUFFER_ADDR_BITS'(cmd_x0);
          wr_next_color = cmd_color;
        end
      end
      ST_FILL: begin
        if (!abort && !last_pixel) begin
          wr_next_en   = 1'b1;
          wr_next_addr = row_end ? (row_base_reg + ROW_STEP + BUFFER_ADDR_BITS'(x0_reg))
                                 : (addr_reg + BUFFER_ADDR_BITS'(1));
        end
      end
      default: ;
    endcase
  end

  fb_rect_fill_write_lane #(
    .CHANNEL_BITS (CHANNEL_BITS)
  ) u_write_lane (
    .en    (wr_next_en),
    .lane  (wr_next_addr[1:0]),
    .color (wr_next_color),
    .we    (lane_we),
    .din   (lane_din)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      x0_reg        <= '0;
      x1_reg        <= '0;
      y_reg         <= '0;
      y1_reg        <= '0;
      row_base_reg  <= '0;
      addr_reg      <= '0;
      color_reg     <= '0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      en_reg        <= 1'b0;
      we_reg        <= '0;
      din_reg       <= '0;
    end else begin
      en_reg  <= wr_next_en;
      we_reg  <= lane_we;
      din_reg <= lane_din;
      if (wr_next_en) addr_reg <= wr_next_addr;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_accept) begin
            x0_reg        <= cmd_x0;
            x1_reg        <= x1_clip;
            y1_reg        <= y1_clip;
            x_reg         <= cmd_x0;
            y_reg         <= cmd_y0;
            row_base_reg  <= start_row_base;
            color_reg     <= cmd_color;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (cmd_empty) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (abort || last_pixel) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (row_end) begin
            x_reg        <= x0_reg;
            y_reg        <= y_reg + Y_BITS'(1);
            row_base_reg <= row_base_reg + ROW_STEP;
          end else begin
            x_reg <= x_reg + X_BITS'(1);
          end
        end
        ST_DONE: begin
          state_reg     <= ST_IDLE;
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_IDLE;
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign buffer_en   = en_reg;
  assign buffer_we   = we_reg;
  assign buffer_din  = din_reg;
  assign buffer_addr = {{(32 - BUFFER_ADDR_BITS){1'b0}}, addr_reg};
  assign buffer_rst  = 1'b0;

endmodule
